// File: rtl/tally_pkg.sv
// Shared types and default sizes for the activation tally stage.
package tally_pkg;
  typedef enum logic [1:0] {ST_ACCUM, ST_SCAN, ST_DONE} state_e;
  localparam int DEF_N_NEURONS = 8;
  localparam int DEF_CNT_W     = 8;
  localparam int SCNT_W        = 16;
endpackage

// File: rtl/activation_tally_if.sv
// Sample handshake and vote-result bus between the perceptron array and the tally.
interface activation_tally_if #(
  parameter int N_NEURONS = 8,
  parameter int CNT_W     = 8
);
  localparam int IDX_W = (N_NEURONS > 1) ? $clog2(N_NEURONS) : 1;
  logic [N_NEURONS-1:0] act_in;
  logic                 in_valid;
  logic                 in_ready;
  logic [IDX_W-1:0]     winner;
  logic [CNT_W-1:0]     winner_cnt;
  logic                 tie;
  logic                 result_valid;

  modport master (output act_in, in_valid,
                  input  in_ready, winner, winner_cnt, tie, result_valid);
  modport slave  (input  act_in, in_valid,
                  output in_ready, winner, winner_cnt, tie, result_valid);
endinterface

// File: rtl/sat_counter.sv
// Per-neuron fire counter: clear has priority over increment, sticks at all-ones.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         ena_i,
  input  logic         clr_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);
  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)                      cnt_d = '0;
    else if (inc_i && ~&cnt_q)      cnt_d = cnt_q + W'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n)     cnt_q <= '0;
    else if (ena_i) cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;
endmodule

// File: rtl/activation_tally.sv
// Windowed fire-count vote: accumulate WINDOW samples, scan one neuron per
// cycle for the argmax, publish winner/count/tie with a one-cycle pulse.
module activation_tally
  import tally_pkg::*;
#(
  parameter int N_NEURONS = DEF_N_NEURONS,
  parameter int CNT_W     = DEF_CNT_W,
  parameter int WINDOW    = 16
) (
  input logic               clk,
  input logic               rst_n,
  input logic               ena,
  activation_tally_if.slave bus
);
  localparam int IDX_W = (N_NEURONS > 1) ? $clog2(N_NEURONS) : 1;

  state_e                         state_q, state_d;
  logic [SCNT_W-1:0]              smp_q, smp_d;
  logic [IDX_W-1:0]               idx_q, idx_d, max_idx_q, max_idx_d, win_q, win_d;
  logic [CNT_W-1:0]               max_q, max_d, wcnt_q, wcnt_d;
  logic                           run_tie_q, run_tie_d, tie_q, tie_d;
  logic [N_NEURONS-1:0][CNT_W-1:0] cnt;
  logic [CNT_W-1:0]               cur;
  logic                           accept, clr;

  assign accept = ena & bus.in_valid & (state_q == ST_ACCUM);
  assign clr    = (state_q == ST_DONE);

  for (genvar i = 0; i < N_NEURONS; i++) begin : g_cnt
    sat_counter #(.W(CNT_W)) u_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .ena_i (ena),
      .clr_i (clr),
      .inc_i (accept & bus.act_in[i]),
      .cnt_o (cnt[i])
    );
  end

  assign cur = cnt[idx_q];

  always_comb begin
    state_d   = state_q;
    smp_d     = smp_q;
    idx_d     = idx_q;
    max_d     = max_q;
    max_idx_d = max_idx_q;
    run_tie_d = run_tie_q;
    win_d     = win_q;
    wcnt_d    = wcnt_q;
    tie_d     = tie_q;
    case (state_q)
      ST_ACCUM: if (accept) begin
        smp_d = smp_q + SCNT_W'(1);
        if (smp_q == SCNT_W'(WINDOW - 1)) begin
          state_d = ST_SCAN;
          idx_d   = '0;
        end
      end
      ST_SCAN: begin
        // Strictly-greater replace keeps the lowest index on ties.
        if (idx_q == '0 || cur > max_q) begin
          max_d     = cur;
          max_idx_d = idx_q;
          run_tie_d = 1'b0;
        end else if (cur == max_q) begin
          run_tie_d = 1'b1;
        end
        idx_d = idx_q + IDX_W'(1);
        if (idx_q == IDX_W'(N_NEURONS - 1)) begin
          state_d = ST_DONE;
          win_d   = max_idx_d;
          wcnt_d  = max_d;
          tie_d   = run_tie_d;
        end
      end
      ST_DONE: begin
        state_d = ST_ACCUM;
        smp_d   = '0;
      end
      default: state_d = ST_ACCUM;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_ACCUM;
      smp_q     <= '0;
      idx_q     <= '0;
      max_q     <= '0;
      max_idx_q <= '0;
      run_tie_q <= 1'b0;
      win_q     <= '0;
      wcnt_q    <= '0;
      tie_q     <= 1'b0;
    end else if (ena) begin
      state_q   <= state_d;
      smp_q     <= smp_d;
      idx_q     <= idx_d;
      max_q     <= max_d;
      max_idx_q <= max_idx_d;
      run_tie_q <= run_tie_d;
      win_q     <= win_d;
      wcnt_q    <= wcnt_d;
      tie_q     <= tie_d;
    end
  end

  assign bus.in_ready     = (state_q == ST_ACCUM);
  assign bus.result_valid = (state_q == ST_DONE);
  assign bus.winner       = win_q;
  assign bus.winner_cnt   = wcnt_q;
  assign bus.tie          = tie_q;
endmodule

// File: tb/tb_activation_tally.sv
// Vote-tally bench: window-level reference model, directed window table,
// reset/enable sequences, a saturating narrow-counter instance and random traffic.
module tb_activation_tally;
  localparam int N    = 8;
  localparam int CW   = 8;
  localparam int WIN  = 16;
  localparam int CW1  = 4;
  localparam int WIN1 = 20;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic ena = 1'b0;
  always #5 clk = ~clk;

  activation_tally_if #(.N_NEURONS(N), .CNT_W(CW))  bus0 ();
  activation_tally_if #(.N_NEURONS(N), .CNT_W(CW1)) bus1 ();

  activation_tally #(.N_NEURONS(N), .CNT_W(CW), .WINDOW(WIN)) dut0 (
    .clk(clk), .rst_n(rst_n), .ena(ena), .bus(bus0.slave));
  activation_tally #(.N_NEURONS(N), .CNT_W(CW1), .WINDOW(WIN1)) dut1 (
    .clk(clk), .rst_n(rst_n), .ena(ena), .bus(bus1.slave));

  int errs = 0, checks = 0;

  // Reference: counts per window, results computed once the window completes;
  // busy counts the N+1 enabled cycles that follow the last sample.
  int m_cnt [N];
  int m_n, m_busy;
  int p_win, p_cnt;
  int e_win, e_cnt, e_tie, p_tie;
  int edge_no = 0, last_rv_edge = -1, rv_period = 0, rv_count = 0;
  logic prev_rv = 1'b0;
  int obs_win, obs_cnt, obs_tie;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, edge_no);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < N; i++) m_cnt[i] = 0;
    m_n = 0;
  endtask

  task automatic model_step();
    int nt;
    if (!rst_n) begin
      model_clear();
      m_busy = 0; e_win = 0; e_cnt = 0; e_tie = 0;
    end else if (ena) begin
      if (m_busy == 0) begin
        if (bus0.in_valid) begin
          for (int i = 0; i < N; i++)
            if (bus0.act_in[i] && m_cnt[i] < (1 << CW) - 1) m_cnt[i]++;
          m_n++;
          if (m_n == WIN) begin
            p_cnt = -1;
            for (int i = 0; i < N; i++)
              if (m_cnt[i] > p_cnt) begin p_cnt = m_cnt[i]; p_win = i; end
            nt = 0;
            for (int i = 0; i < N; i++) if (m_cnt[i] == p_cnt) nt++;
            p_tie = (nt > 1) ? 1 : 0;
            model_clear();
            m_busy = N + 1;
          end
        end
      end else begin
        m_busy--;
        if (m_busy == 1) begin e_win = p_win; e_cnt = p_cnt; e_tie = p_tie; end
      end
    end
  endtask

  task automatic cyc(input logic v, input logic [N-1:0] a);
    bus0.in_valid = v;
    bus0.act_in   = a;
    model_step();
    @(posedge clk); #1;
    edge_no++;
    chk("in_ready",     32'(bus0.in_ready),     32'(m_busy == 0));
    chk("result_valid", 32'(bus0.result_valid), 32'(m_busy == 1));
    chk("winner",       32'(bus0.winner),       32'(e_win));
    chk("winner_cnt",   32'(bus0.winner_cnt),   32'(e_cnt));
    chk("tie",          32'(bus0.tie),          32'(e_tie));
    if (bus0.result_valid && !prev_rv) begin
      if (last_rv_edge >= 0) rv_period = edge_no - last_rv_edge;
      last_rv_edge = edge_no;
      rv_count++;
      obs_win = int'(bus0.winner);
      obs_cnt = int'(bus0.winner_cnt);
      obs_tie = int'(bus0.tie);
    end
    prev_rv = bus0.result_valid;
  endtask

  typedef struct {
    logic [N-1:0] a;
    logic [N-1:0] b;
    int win;
    int cnt;
    int tie;
  } vec_t;
  vec_t tbl [6];

  initial begin
    int rv0;
    bit got;
    tbl[0] = '{8'h04, 8'h04, 2, 16, 1'b0};
    tbl[1] = '{8'h81, 8'h01, 0, 16, 1'b0};
    tbl[2] = '{8'h88, 8'h88, 3, 16, 1'b1};
    tbl[3] = '{8'h00, 8'h00, 0, 0,  1'b1};
    tbl[4] = '{8'h0F, 8'hF0, 0, 8,  1'b1};
    tbl[5] = '{8'h06, 8'h02, 1, 16, 1'b0};

    bus1.in_valid = 1'b0;
    bus1.act_in   = '0;
    ena   = 1'b1;
    rst_n = 1'b0;
    cyc(1'b0, '0);
    cyc(1'b0, '0);
    rst_n = 1'b1;

    // Directed windows back to back; in_valid stays high with 8'hFF through SCAN/DONE.
    for (int t = 0; t < 6; t++) begin
      rv0 = rv_count;
      for (int s = 0; s < WIN; s++) cyc(1'b1, (s % 2 == 0) ? tbl[t].a : tbl[t].b);
      for (int s = 0; s < N + 1; s++) cyc(1'b1, 8'hFF);
      chk("tbl_pulses", 32'(rv_count - rv0), 32'd1);
      chk("tbl_winner", 32'(obs_win), 32'(tbl[t].win));
      chk("tbl_cnt",    32'(obs_cnt), 32'(tbl[t].cnt));
      chk("tbl_tie",    32'(obs_tie), 32'(tbl[t].tie));
      if (t > 0) chk("period", 32'(rv_period), 32'(WIN + N + 1));
    end

    // Abort a partial window with reset, then a clean window.
    rv0 = rv_count;
    for (int s = 0; s < 10; s++) cyc(1'b1, 8'h02);
    rst_n = 1'b0;
    cyc(1'b1, 8'h02);
    rst_n = 1'b1;
    for (int s = 0; s < WIN; s++) cyc(1'b1, 8'h40);
    for (int s = 0; s < N + 1; s++) cyc(1'b0, '0);
    chk("rst_pulses", 32'(rv_count - rv0), 32'd1);
    chk("rst_winner", 32'(obs_win), 32'd6);
    chk("rst_cnt",    32'(obs_cnt), 32'd16);
    chk("rst_tie",    32'(obs_tie), 32'd0);

    // ena low for 5 cycles mid-window stretches the period by 5.
    for (int s = 0; s < 8; s++) cyc(1'b1, 8'h10);
    ena = 1'b0;
    for (int s = 0; s < 5; s++) cyc(1'b1, 8'hFF);
    ena = 1'b1;
    for (int s = 0; s < 8; s++) cyc(1'b1, 8'h10);
    for (int s = 0; s < N + 1; s++) cyc(1'b1, 8'h10);
    chk("ena_period", 32'(rv_period), 32'(WIN + N + 1 + 5));
    chk("ena_winner", 32'(obs_win), 32'd4);
    chk("ena_cnt",    32'(obs_cnt), 32'd16);

    // Narrow-counter instance: 20 fires into a 4-bit counter saturate at 15.
    rst_n = 1'b0;
    cyc(1'b0, '0);
    rst_n = 1'b1;
    bus1.in_valid = 1'b1;
    bus1.act_in   = 8'h01;
    for (int s = 0; s < WIN1; s++) begin
      chk("sat_ready", 32'(bus1.in_ready), 32'd1);
      cyc(1'b0, '0);
    end
    bus1.in_valid = 1'b0;
    got = 1'b0;
    for (int s = 0; s < 40 && !got; s++) begin
      if (bus1.result_valid) begin
        got = 1'b1;
        chk("sat_cnt",    32'(bus1.winner_cnt), 32'd15);
        chk("sat_winner", 32'(bus1.winner),     32'd0);
        chk("sat_tie",    32'(bus1.tie),        32'd0);
      end else cyc(1'b0, '0);
    end
    chk("sat_timeout", 32'(got), 32'd1);

    // Random traffic, including enable gaps and occasional resets.
    for (int s = 0; s < 1500; s++) begin
      ena   = ($urandom_range(0, 9) != 0);
      rst_n = ($urandom_range(0, 199) != 0);
      cyc(1'($urandom_range(0, 3) != 0), N'($urandom));
    end
    rst_n = 1'b1;
    ena   = 1'b1;
    for (int s = 0; s < 30; s++) cyc(1'b1, 8'h20);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
